core_control_fsm: RTL

Multicycle sequencer for the RV32I core: drives every strobe and mux select of the control signal bundle (write_pc/ir/rd, mem_read/write, addr_sel, rd_sel, alu_insel1/2) from the decoded opcode and memory/exception status. It sits between the decoder/memory interface and the datapath and provides a debug halt/resume handshake at instruction boundaries, plus a sticky trap stop.

---
 rtl/core_control_pkg.sv | 60 ++++++
 rtl/core_control_fsm.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/core_control_pkg.sv
// core_control_pkg
// Shared types and constants for the multicycle control sequencer:
//   - RV32I major opcode encodings (7-bit) and their width
//   - state_t         : sequencer states
//   - alu_in1_t/2_t   : ALU operand mux selects
//   - ADDR_SEL_*/RD_SEL_* : memory address and rd write-back mux selects
//   - trap_cause_t    : cause code reported while trapped
package core_control_pkg;

   localparam int ISA_OPCODE_WIDTH = 7;

   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_LOAD     = 7'b0000011;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_STORE    = 7'b0100011;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_OP       = 7'b0110011;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_LUI      = 7'b0110111;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_JALR     = 7'b1100111;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_JAL      = 7'b1101111;
   localparam logic [ISA_OPCODE_WIDTH-1:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      ST_START,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_JUMP,
      ST_PCINC,
      ST_HALTED,
      ST_TRAP
   } state_t;

   typedef enum logic [1:0] {
      ALU_IN1_RS1  = 2'd0,
      ALU_IN1_PC   = 2'd1,
      ALU_IN1_ZERO = 2'd2
   } alu_in1_t;

   typedef enum logic [1:0] {
      ALU_IN2_RS2  = 2'd0,
      ALU_IN2_IMM  = 2'd1,
      ALU_IN2_FOUR = 2'd2
   } alu_in2_t;

   localparam logic ADDR_SEL_PC  = 1'b0;
   localparam logic ADDR_SEL_ALU = 1'b1;
   localparam logic RD_SEL_ALU   = 1'b0;
   localparam logic RD_SEL_MEM   = 1'b1;

   typedef enum logic [1:0] {
      TRAP_IALIGN       = 2'd0,
      TRAP_ILLEGAL      = 2'd1,
      TRAP_LOAD_MALIGN  = 2'd2,
      TRAP_STORE_MALIGN = 2'd3
   } trap_cause_t;

endpackage

// File: rtl/core_control_fsm.sv
// core_control_fsm
// Multicycle sequencer for the RV32I core. Drives all datapath strobes and
// mux selects from the current state, the opcode held in IR and the memory /
// decoder status. Offers a debug halt/resume handshake at instruction
// boundaries and a sticky trap stop that only reset clears.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   opcode                     opcode of the instruction in IR
//   invalid_inst, ialign       decoder status
//   mem_complete_read/write    memory handshake completion
//   mem_malign                 memory access misaligned
//   branch_taken               comparator result for BRANCH
//   halt_req, resume_req       debug request levels
//   write_pc/ir/rd, mem_read/write, addr_sel, rd_sel, alu_insel1/2
//                              combinational control strobes/selects
//   halted, trap, trap_cause   state-decoded status outputs
module core_control_fsm
   import core_control_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [ISA_OPCODE_WIDTH-1:0] opcode,
   input  logic                        invalid_inst,
   input  logic                        ialign,
   input  logic                        mem_complete_read,
   input  logic                        mem_complete_write,
   input  logic                        mem_malign,
   input  logic                        branch_taken,
   input  logic                        halt_req,
   input  logic                        resume_req,
   output logic                        write_pc,
   output logic                        write_ir,
   output logic                        write_rd,
   output logic                        mem_read,
   output logic                        mem_write,
   output logic                        addr_sel,
   output logic                        rd_sel,
   output logic [1:0]                  alu_insel1,
   output logic [1:0]                  alu_insel2,
   output logic                        halted,
   output logic                        trap,
   output logic [1:0]                  trap_cause
);

   state_t      state_q, state_d;
   trap_cause_t cause_q, cause_d;
   // High in the first cycle spent in a state; misalignment is only sampled
   // then, before any memory request is outstanding.
   logic        first_q, first_d;
   alu_in1_t    in1;
   alu_in2_t    in2;

   // Every entry into FETCH is an instruction boundary where a halt lands.
   function automatic state_t next_fetch(input logic halt);
      return halt ? ST_HALTED : ST_FETCH;
   endfunction

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      write_pc  = 1'b0;
      write_ir  = 1'b0;
      write_rd  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_sel  = ADDR_SEL_PC;
      rd_sel    = RD_SEL_ALU;
      in1       = ALU_IN1_RS1;
      in2       = ALU_IN2_RS2;

      case (state_q)
         ST_START: state_d = next_fetch(halt_req);

         ST_FETCH: begin
            if (first_q && ialign) begin
               state_d = ST_TRAP;
               cause_d = TRAP_IALIGN;
            end else begin
               mem_read = 1'b1;
               addr_sel = ADDR_SEL_PC;
               if (mem_complete_read) begin
                  write_ir = 1'b1;
                  state_d  = ST_DECODE;
               end
            end
         end

         ST_DECODE: begin
            if (invalid_inst) begin
               state_d = ST_TRAP;
               cause_d = TRAP_ILLEGAL;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            state_d = ST_PCINC;
            case (opcode)
               OPC_OP: write_rd = 1'b1;
               OPC_OP_IMM: begin
                  in2      = ALU_IN2_IMM;
                  write_rd = 1'b1;
               end
               OPC_LUI: begin
                  in1      = ALU_IN1_ZERO;
                  in2      = ALU_IN2_IMM;
                  write_rd = 1'b1;
               end
               OPC_AUIPC: begin
                  in1      = ALU_IN1_PC;
                  in2      = ALU_IN2_IMM;
                  write_rd = 1'b1;
               end
               OPC_LOAD, OPC_STORE: begin
                  in2      = ALU_IN2_IMM;
                  addr_sel = ADDR_SEL_ALU;
                  state_d  = ST_MEM;
               end
               OPC_JAL, OPC_JALR: begin
                  // Link value PC+4 is written before PC is redirected.
                  in1      = ALU_IN1_PC;
                  in2      = ALU_IN2_FOUR;
                  write_rd = 1'b1;
                  rd_sel   = RD_SEL_ALU;
                  state_d  = ST_JUMP;
               end
               OPC_BRANCH: begin
                  if (branch_taken) state_d = ST_JUMP;
               end
               default: ; // MISC_MEM, SYSTEM: nothing to do but advance PC
            endcase
         end

         ST_MEM: begin
            in2      = ALU_IN2_IMM;
            addr_sel = ADDR_SEL_ALU;
            if (first_q && mem_malign) begin
               state_d = ST_TRAP;
               cause_d = (opcode == OPC_STORE) ? TRAP_STORE_MALIGN : TRAP_LOAD_MALIGN;
            end else if (opcode == OPC_STORE) begin
               mem_write = 1'b1;
               if (mem_complete_write) state_d = ST_PCINC;
            end else begin
               mem_read = 1'b1;
               if (mem_complete_read) begin
                  write_rd = 1'b1;
                  rd_sel   = RD_SEL_MEM;
                  state_d  = ST_PCINC;
               end
            end
         end

         ST_JUMP: begin
            in1      = (opcode == OPC_JALR) ? ALU_IN1_RS1 : ALU_IN1_PC;
            in2      = ALU_IN2_IMM;
            write_pc = 1'b1;
            state_d  = next_fetch(halt_req);
         end

         ST_PCINC: begin
            in1      = ALU_IN1_PC;
            in2      = ALU_IN2_FOUR;
            write_pc = 1'b1;
            state_d  = next_fetch(halt_req);
         end

         ST_HALTED: begin
            // Halt has priority when both requests are high.
            if (resume_req && !halt_req) state_d = ST_FETCH;
         end

         ST_TRAP: ; // sticky until reset

         default: state_d = ST_START;
      endcase

      first_d = (state_d != state_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_START;
         cause_q <= TRAP_IALIGN;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         first_q <= first_d;
      end
   end

   assign alu_insel1 = in1;
   assign alu_insel2 = in2;
   assign halted     = (state_q == ST_HALTED);
   assign trap       = (state_q == ST_TRAP);
   assign trap_cause = (state_q == ST_TRAP) ? cause_q : TRAP_IALIGN;

endmodule
